pipeline_interlock_ctrl: RTL and testbench
==========================================

Name: pipeline_interlock_ctrl

Overview:
Consumes hazard and stall requests from the RV32 5-stage pipeline and applies them. Inputs are the load-to-use stall from the fetch/decode hazard check, instruction/data memory busy, and the execute-stage redirect. It drives the PC write enable, the per-stage pipeline-register write enables, the fetch/decode flush and the decode/execute bubble insert. A small FSM handles multi-cycle memory freezes and multi-slot redirect flushes.

Parameters:
FLUSH_CYCLES, 1, fetch slots squashed per redirect (covers imem latency); legal range 1..15
MEM_TIMEOUT, 255, consecutive mem_busy_i cycles before mem_timeout_o sets; 0 disables
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_use_stall_i  in  1  load-to-use RAW between fetch and decode instructions
imem_busy_i  in  1  instruction memory has no valid fetch this cycle
mem_busy_i  in  1  data memory not ready; whole pipeline must freeze
redirect_i  in  1  taken branch/jump resolved in execute; PC loads target
pc_we_o  out  1  PC register write enable
fd_we_o  out  1  fetch/decode register write enable
fd_flush_o  out  1  load NOP into fetch/decode (effective only with fd_we_o=1)
dx_we_o  out  1  decode/execute register write enable
dx_bubble_o  out  1  load NOP into decode/execute (effective only with dx_we_o=1)
xm_we_o  out  1  execute/memory register write enable
mw_we_o  out  1  memory/writeback register write enable
mem_timeout_o  out  1  sticky: data memory exceeded MEM_TIMEOUT
stall_cycles_o  out  CNT_W  cycles with pc_we_o=0 (optional feature)
bubble_cycles_o  out  CNT_W  cycles with dx_bubble_o=1 (optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state:
  - state=RUN, flush counter=0, timeout counter=0, mem_timeout_o=0, perf counters=0.
  - While rst_n=0: all *_we_o=0, fd_flush_o=1, dx_bubble_o=1.
- Output timing: outputs are combinational from registered state plus current inputs, so they respond in the same cycle. The state update is registered.
- Priority within a cycle: mem_busy_i > redirect_i > load_use_stall_i > imem_busy_i.
- Default (RUN, no request): all *_we_o=1, fd_flush_o=0, dx_bubble_o=0.
- States: RUN, MEM_WAIT, FLUSH.
- RUN:
  - mem_busy_i: all *_we_o=0; go to MEM_WAIT; timeout counter=1.
  - redirect_i: default enables plus fd_flush_o=1 and dx_bubble_o=1.
    - FLUSH_CYCLES>1: go to FLUSH with counter=FLUSH_CYCLES-1.
    - Otherwise: stay in RUN.
  - load_use_stall_i: pc_we_o=0, fd_we_o=0, dx_bubble_o=1; others 1. Stay in RUN; the request repeats every cycle it is asserted.
  - imem_busy_i: pc_we_o=0, fd_flush_o=1; others default.
- MEM_WAIT:
  - mem_busy_i=1: all *_we_o=0. Timeout counter saturating-increments. When the counter reaches MEM_TIMEOUT (≠0), mem_timeout_o sets and holds until reset. redirect_i, load_use_stall_i and imem_busy_i are ignored.
  - mem_busy_i=0: behave exactly as RUN for this cycle (all RUN rules apply, including entering FLUSH). Timeout counter clears.
- FLUSH:
  - Default: pc_we_o=1, fd_we_o=1, fd_flush_o=1, dx_bubble_o=0, others 1. Counter decrements; at 1→0 return to RUN.
  - mem_busy_i: all *_we_o=0; counter holds; stay in FLUSH. The timeout counter runs as in MEM_WAIT.
  - redirect_i: reload counter=FLUSH_CYCLES-1 and assert dx_bubble_o=1.
  - load_use_stall_i and imem_busy_i are ignored (decode holds only squashed slots).
- Simultaneous mem_busy_i and redirect_i: the freeze wins. Redirect must be re-presented by execute, which is frozen and therefore holds it.
- Asynchronous reset mid-MEM_WAIT or mid-FLUSH: state immediately returns to RUN, counters clear, outputs follow the reset values above.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: stall_cycles_o increments each cycle pc_we_o=0 and rst_n=1. bubble_cycles_o increments each cycle dx_bubble_o=1 and dx_we_o=1. Both wrap at 2^CNT_W and reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops are built.

Test Plan:
- Load-use: RUN, load_use_stall_i=1 for 1 cycle → that cycle pc_we_o=0, fd_we_o=0, dx_bubble_o=1, xm_we_o=mw_we_o=1. Next cycle all defaults.
- Memory freeze and timeout (MEM_TIMEOUT=4): mem_busy_i=1 for 6 cycles → all *_we_o=0 for 6 cycles; mem_timeout_o=1 from the 4th busy cycle edge and stays 1 after busy drops. Release cycle shows default enables.
- Redirect (FLUSH_CYCLES=3): redirect_i 1 cycle → cycle0 fd_flush_o=1 and dx_bubble_o=1; cycles 1–2 fd_flush_o=1 and dx_bubble_o=0; cycle 3 defaults.
- Freeze inside FLUSH (FLUSH_CYCLES=3): mem_busy_i for 2 cycles at flush cycle 1 → enables 0 for 2 cycles, then 2 remaining flush cycles complete.
- Priority: mem_busy_i, redirect_i and load_use_stall_i all asserted in RUN → all *_we_o=0, state becomes MEM_WAIT. Release with redirect_i held → flush sequence starts on the release cycle.
- Async reset mid-FLUSH: drop rst_n between clock edges → outputs go to the reset values immediately. After release, RUN defaults and counters (with STALL_PERF_CNT_EN) read 0.

Source files
------------

// File: rtl/pipeline_interlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_interlock_ctrl
// Description : Turns the pipeline's hazard and stall requests into a PC write
//               enable, per-stage register write enables, the fetch/decode
//               flush and the decode/execute bubble. A small FSM covers
//               multi-cycle data-memory freezes and multi-slot redirect
//               flushes. Define STALL_PERF_CNT_EN to build the stall and
//               bubble performance counters; without it the counter ports
//               are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_interlock_ctrl #(
    parameter int FLUSH_CYCLES = 1,    // fetch slots squashed per redirect, 1..15
    parameter int MEM_TIMEOUT  = 255,  // busy cycles before timeout flag; 0 disables
    parameter int CNT_W        = 32    // performance counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall_i,
    input  logic             imem_busy_i,
    input  logic             mem_busy_i,
    input  logic             redirect_i,
    output logic             pc_we_o,
    output logic             fd_we_o,
    output logic             fd_flush_o,
    output logic             dx_we_o,
    output logic             dx_bubble_o,
    output logic             xm_we_o,
    output logic             mw_we_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] bubble_cycles_o
);

    // The timeout counter saturates at the threshold, so it only needs to be
    // wide enough to hold it. A disabled timeout still gets a 1-bit counter.
    localparam int       TMO_MAX      = (MEM_TIMEOUT == 0) ? 1 : MEM_TIMEOUT;
    localparam int       TMO_W        = $clog2(TMO_MAX + 1);
    localparam bit       TMO_EN       = (MEM_TIMEOUT != 0);
    localparam bit       MULTI_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       flush_cnt;
    logic [3:0]       flush_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic             tmo_hit;

    // State, flush-slot counter, busy-run counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            flush_cnt     <= 4'd0;
            tmo_cnt       <= '0;
            mem_timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            if (tmo_hit) begin
                mem_timeout_o <= 1'b1;
            end
        end
    end

    // Busy-run length: counts consecutive data-memory busy cycles in any state
    always_comb begin
        tmo_cnt_nxt = '0;
        if (mem_busy_i) begin
            tmo_cnt_nxt = (tmo_cnt == TMO_W'(TMO_MAX)) ? tmo_cnt
                                                       : tmo_cnt + TMO_W'(1);
        end
        tmo_hit = TMO_EN && mem_busy_i && (tmo_cnt_nxt == TMO_W'(TMO_MAX));
    end

    // Next state and enables; a freeze overrides everything, and a released
    // MEM_WAIT behaves exactly like RUN for that cycle
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pc_we_o       = 1'b1;
        fd_we_o       = 1'b1;
        fd_flush_o    = 1'b0;
        dx_we_o       = 1'b1;
        dx_bubble_o   = 1'b0;
        xm_we_o       = 1'b1;
        mw_we_o       = 1'b1;

        if (mem_busy_i) begin
            // Whole pipeline frozen; FLUSH keeps its remaining slot count
            pc_we_o = 1'b0;
            fd_we_o = 1'b0;
            dx_we_o = 1'b0;
            xm_we_o = 1'b0;
            mw_we_o = 1'b0;
            if (state == RUN) begin
                state_nxt = MEM_WAIT;
            end
        end else if (state == FLUSH) begin
            // Decode only holds squashed slots, so load-use and imem busy
            // are irrelevant here
            fd_flush_o = 1'b1;
            if (redirect_i) begin
                dx_bubble_o   = 1'b1;
                flush_cnt_nxt = FLUSH_RELOAD;
            end else if (flush_cnt <= 4'd1) begin
                flush_cnt_nxt = 4'd0;
                state_nxt     = RUN;
            end else begin
                flush_cnt_nxt = flush_cnt - 4'd1;
            end
        end else begin
            state_nxt = RUN;
            if (redirect_i) begin
                fd_flush_o  = 1'b1;
                dx_bubble_o = 1'b1;
                if (MULTI_FLUSH) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_RELOAD;
                end
            end else if (load_use_stall_i) begin
                pc_we_o     = 1'b0;
                fd_we_o     = 1'b0;
                dx_bubble_o = 1'b1;
            end else if (imem_busy_i) begin
                pc_we_o    = 1'b0;
                fd_flush_o = 1'b1;
            end
        end

        // Safe values while reset is held: nothing advances, NOPs injected
        if (!rst_n) begin
            pc_we_o     = 1'b0;
            fd_we_o     = 1'b0;
            fd_flush_o  = 1'b1;
            dx_we_o     = 1'b0;
            dx_bubble_o = 1'b1;
            xm_we_o     = 1'b0;
            mw_we_o     = 1'b0;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Wrapping counters of PC-hold cycles and bubbles actually inserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!pc_we_o) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (dx_bubble_o && dx_we_o) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o  = stall_cnt;
    assign bubble_cycles_o = bubble_cnt;
`else
    assign stall_cycles_o  = '0;
    assign bubble_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_interlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_interlock_ctrl
// Description : Self-checking bench for pipeline_interlock_ctrl with
//               FLUSH_CYCLES=3 and MEM_TIMEOUT=4. Directed scenarios followed
//               by random request traffic, compared each cycle against a
//               slot-counting reference model. Honours STALL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_interlock_ctrl;

    localparam int FC    = 3;
    localparam int MT    = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_use_stall_i, imem_busy_i, mem_busy_i, redirect_i;
    logic             pc_we_o, fd_we_o, fd_flush_o, dx_we_o, dx_bubble_o;
    logic             xm_we_o, mw_we_o, mem_timeout_o;
    logic [CNT_W-1:0] stall_cycles_o, bubble_cycles_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: squash slots still owed, length of the current busy
    // run, sticky timeout, and expected counter values
    int          flush_left;
    int          busy_len;
    bit          timed_out;
    longint      stall_cnt;
    longint      bubble_cnt;

    pipeline_interlock_ctrl #(
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (MT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_stall_i (load_use_stall_i),
        .imem_busy_i      (imem_busy_i),
        .mem_busy_i       (mem_busy_i),
        .redirect_i       (redirect_i),
        .pc_we_o          (pc_we_o),
        .fd_we_o          (fd_we_o),
        .fd_flush_o       (fd_flush_o),
        .dx_we_o          (dx_we_o),
        .dx_bubble_o      (dx_bubble_o),
        .xm_we_o          (xm_we_o),
        .mw_we_o          (mw_we_o),
        .mem_timeout_o    (mem_timeout_o),
        .stall_cycles_o   (stall_cycles_o),
        .bubble_cycles_o  (bubble_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flush_left = 0;
        busy_len   = 0;
        timed_out  = 0;
        stall_cnt  = 0;
        bubble_cnt = 0;
    endtask

    // Output vector order: pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we
    function automatic logic [6:0] outs();
        return {pc_we_o, fd_we_o, fd_flush_o, dx_we_o, dx_bubble_o, xm_we_o, mw_we_o};
    endfunction

    task automatic check_counters(input string tag);
`ifdef STALL_PERF_CNT_EN
        check({tag, "_stall_cnt"},  64'(stall_cycles_o),  64'(stall_cnt[CNT_W-1:0]));
        check({tag, "_bubble_cnt"}, 64'(bubble_cycles_o), 64'(bubble_cnt[CNT_W-1:0]));
`else
        check({tag, "_stall_cnt"},  64'(stall_cycles_o),  64'd0);
        check({tag, "_bubble_cnt"}, 64'(bubble_cycles_o), 64'd0);
`endif
    endtask

    // One clock cycle: drive requests, compare against the model, advance model
    task automatic step(input string tag, input bit mb, input bit rd, input bit lu, input bit ib);
        logic [6:0] e;
        logic [6:0] mask;
        @(negedge clk);
        mem_busy_i       = mb;
        redirect_i       = rd;
        load_use_stall_i = lu;
        imem_busy_i      = ib;
        #1;
        mask = 7'b1111111;
        if (mb) begin
            e    = 7'b0000000;
            mask = 7'b1101011;        // only enables matter while frozen
        end else if (flush_left > 0) e = {4'b1111, rd, 2'b11};
        else if (rd)                  e = 7'b1111111;
        else if (lu)                  e = 7'b0001111;
        else if (ib)                  e = 7'b0111011;
        else                          e = 7'b1101011;
        check({tag, "_outs"}, 64'(outs() & mask), 64'(e & mask));
        check({tag, "_timeout"}, 64'(mem_timeout_o), 64'(timed_out));
        check_counters(tag);

        if (!e[6]) stall_cnt++;
        if (e[3] && e[2] && !mb) bubble_cnt++;
        if (mb) begin
            if (busy_len < 1000) busy_len++;
            if (MT != 0 && busy_len >= MT) timed_out = 1;
        end else begin
            busy_len = 0;
            if (rd)                  flush_left = FC - 1;
            else if (flush_left > 0) flush_left--;
        end
    endtask

    // Asynchronous reset applied between clock edges, held across one edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        {mem_busy_i, redirect_i, load_use_stall_i, imem_busy_i} = 4'b0;
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_outs"}, 64'(outs()), 64'(7'b0010100));
        check({tag, "_rst_timeout"}, 64'(mem_timeout_o), 64'd0);
        model_reset();
        check_counters({tag, "_rst"});
        @(posedge clk);
        #1;
        check({tag, "_rst_hold_outs"}, 64'(outs()), 64'(7'b0010100));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int streak;
        rst_n = 1'b0;
        {mem_busy_i, redirect_i, load_use_stall_i, imem_busy_i} = 4'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_outs", 64'(outs()), 64'(7'b0010100));
        check("por_timeout", 64'(mem_timeout_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("idle", 0, 0, 0, 0);
        // Load-use for one cycle, then defaults
        step("lu", 0, 0, 1, 0);
        step("lu_after", 0, 0, 0, 0);
        step("imem", 0, 0, 0, 1);
        // Six-cycle memory freeze crossing the timeout threshold
        repeat (6) step("freeze", 1, 0, 0, 0);
        step("freeze_rel", 0, 0, 0, 0);
        step("freeze_post", 0, 0, 0, 0);
        // Single redirect: one bubble slot plus two extra squash slots
        step("redir", 0, 1, 0, 0);
        repeat (3) step("redir_tail", 0, 0, 0, 0);
        // Freeze landing inside the flush sequence
        step("fz_redir", 0, 1, 0, 0);
        repeat (2) step("fz_in_flush", 1, 0, 0, 0);
        repeat (3) step("fz_tail", 0, 0, 0, 0);
        // Priority: freeze beats redirect and load-use, redirect held on release
        step("prio", 1, 1, 1, 0);
        step("prio_rel", 0, 1, 1, 0);
        repeat (2) step("prio_ignored", 0, 0, 1, 1);
        step("prio_tail", 0, 0, 0, 0);
        // Back-to-back redirects reload the squash window
        step("rr0", 0, 1, 0, 0);
        step("rr1", 0, 1, 0, 0);
        repeat (3) step("rr_tail", 0, 0, 0, 0);
        // Asynchronous reset in the middle of a flush
        step("rst_redir", 0, 1, 0, 0);
        step("rst_flush", 0, 0, 0, 0);
        async_reset("midflush");
        step("post_rst", 0, 0, 0, 0);

        // Random traffic with occasional long freezes
        streak = 0;
        for (int i = 0; i < 400; i++) begin
            bit mb;
            if (streak == 0 && $urandom_range(0, 11) == 0) streak = $urandom_range(1, 7);
            mb = (streak > 0);
            if (streak > 0) streak--;
            step("rand", mb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
            if (i == 200) async_reset("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
